encrypt_decrypt: RTL and testbench

ENCRYPT_DECRYPT -- requirements
Module: encrypt_decrypt

---
 rtl/encrypt_decrypt.sv | 96 +++++++++
 tb/tb_encrypt_decrypt.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/encrypt_decrypt.sv
// Iterative XOR/rotate block cipher. One round is applied per clock while busy.
// Encrypt appends a byte-XOR checksum, which decrypt recomputes and compares.
module encrypt_decrypt #(
    parameter int ROUNDS = 4  // legal range 1..8; the round counter is 3 bits wide
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         mode,
    input  logic [63:0]  key,
    input  logic [255:0] data_in,
    output logic         busy,
    output logic         done,
    output logic [255:0] data_out,
    output logic         check_ok
);

    localparam logic [2:0] LAST_ROUND = 3'(ROUNDS - 1);

    logic [255:0] stateReg;
    logic [255:0] nextState;
    logic [255:0] roundKeyVal;
    logic [63:0]  keyReg;
    logic         modeReg;
    logic [2:0]   roundCnt;
    logic [2:0]   keyIdx;

    function automatic logic [7:0] byteXor(input logic [247:0] v);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < 31; i++) begin
            acc ^= v[i*8 +: 8];
        end
        return acc;
    endfunction

    // The replicated key rotated left by 16*idx; rotation by 0 falls out
    // because the right shift by 256 yields zero.
    function automatic logic [255:0] roundKey(input logic [63:0] k, input logic [2:0] idx);
        logic [255:0] rep;
        logic [8:0]   sh;
        rep = {4{k}};
        sh  = {2'b00, idx, 4'b0000};
        return (rep << sh) | (rep >> (9'd256 - sh));
    endfunction

    function automatic logic [255:0] rotl8(input logic [255:0] v);
        return {v[247:0], v[255:248]};
    endfunction

    function automatic logic [255:0] rotr8(input logic [255:0] v);
        return {v[7:0], v[255:8]};
    endfunction

    // Decrypt walks the key schedule backwards so each round undoes its encrypt twin.
    always_comb begin
        keyIdx      = modeReg ? (LAST_ROUND - roundCnt) : roundCnt;
        roundKeyVal = roundKey(keyReg, keyIdx);
        nextState   = modeReg ? (rotr8(stateReg) ^ roundKeyVal)
                              : rotl8(stateReg ^ roundKeyVal);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            check_ok <= 1'b0;
            data_out <= '0;
            stateReg <= '0;
            roundCnt <= '0;
            keyReg   <= '0;
            modeReg  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    modeReg  <= mode;
                    keyReg   <= key;
                    stateReg <= mode ? data_in : {byteXor(data_in[247:0]), data_in[247:0]};
                    roundCnt <= '0;
                    busy     <= 1'b1;
                end
            end else begin
                stateReg <= nextState;
                roundCnt <= roundCnt + 3'd1;
                if (roundCnt == LAST_ROUND) begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    data_out <= nextState;
                    check_ok <= modeReg ? (nextState[255:248] == byteXor(nextState[247:0])) : 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_encrypt_decrypt.sv
// Directed bench for encrypt_decrypt: known vectors, start/busy handling,
// async reset abort and a randomised encrypt/decrypt round trip.
module tb_encrypt_decrypt;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         mode;
    logic [63:0]  key;
    logic [255:0] data_in;
    logic         busy;
    logic         done;
    logic [255:0] data_out;
    logic         check_ok;

    int checks = 0;
    int errors = 0;

    encrypt_decrypt #(.ROUNDS(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .key      (key),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .data_out (data_out),
        .check_ok (check_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [255:0] CT_K15 =
        256'h0F0F0F0F_00000000_0F0F0F0F_00000000_0F0F0F0F_00000000_0F0F0F1B_14000000;
    localparam logic [255:0] CT_K0  = 256'h14_1400_0000;
    localparam logic [255:0] PT20   = {8'h14, 248'd20};

    function automatic logic [7:0] refChk(input logic [247:0] p);
        logic [7:0] x;
        x = 8'h00;
        for (int b = 0; b < 31; b++) x = x ^ p[8*b +: 8];
        return x;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Issues one start, then waits (bounded) for done; lat counts clocks after acceptance.
    task automatic runOp(input logic m, input logic [63:0] k, input logic [255:0] d,
                         output logic [255:0] res, output logic ok, output int lat);
        @(negedge clk);
        start = 1'b1; mode = m; key = k; data_in = d;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) chk("done_timeout", {255'd0, done}, 256'd1);
        res = data_out;
        ok  = check_ok;
    endtask

    initial begin
        logic [255:0] res;
        logic [255:0] ct;
        logic         ok;
        int           lat;
        logic [10:0]  doneSeen;
        logic [247:0] p;
        logic [63:0]  k;

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; key = '0; data_in = '0;
        #1;
        chk("reset_busy", {255'd0, busy}, 256'd0);
        chk("reset_done", {255'd0, done}, 256'd0);
        chk("reset_data_out", data_out, 256'd0);
        chk("reset_check_ok", {255'd0, check_ok}, 256'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Plaintext 20, key 0: four byte rotations of {0x14, ..., 0x14}
        runOp(1'b0, 64'd0, 256'd20, res, ok, lat);
        chk("enc_k0_latency", 256'(lat), 256'd4);
        chk("enc_k0_data", res, CT_K0);
        chk("enc_k0_check_ok", {255'd0, ok}, 256'd1);
        @(posedge clk); #1;
        chk("done_pulse_width", {255'd0, done}, 256'd0);
        chk("data_out_held", data_out, CT_K0);

        // Plaintext 20, key 15 and the matching decrypt
        runOp(1'b0, 64'd15, 256'd20, res, ok, lat);
        chk("enc_k15_data", res, CT_K15);
        chk("enc_k15_check_ok", {255'd0, ok}, 256'd1);
        runOp(1'b1, 64'd15, CT_K15, res, ok, lat);
        chk("dec_k15_latency", 256'(lat), 256'd4);
        chk("dec_k15_data", res, PT20);
        chk("dec_k15_check_ok", {255'd0, ok}, 256'd1);

        // Ciphertext bit 0 flipped lands in result bit 224 and breaks the checksum
        runOp(1'b1, 64'd15, CT_K15 ^ 256'd1, res, ok, lat);
        chk("dec_flip_data", res, PT20 ^ (256'd1 << 224));
        chk("dec_flip_check_ok", {255'd0, ok}, 256'd0);

        // start held for 10 edges: accepts at edge 1 and 6, done after edges 5 and 10
        @(negedge clk);
        start = 1'b1; mode = 1'b0; key = 64'd0; data_in = 256'd20;
        doneSeen = '0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            doneSeen[e] = done;
            if (e == 1) begin
                mode = 1'b1; key = 64'd15; data_in = CT_K15;
            end
            if (e == 4) begin
                mode = 1'b0; key = 64'd0; data_in = 256'd20;
            end
            if (e == 5) chk("hold_first_result", data_out, CT_K0);
        end
        start = 1'b0;
        chk("hold_done_pattern", {245'd0, doneSeen}, {245'd0, 11'b10000100000});
        chk("hold_second_result", data_out, CT_K0);
        @(posedge clk); #1;
        chk("hold_done_cleared", {255'd0, done}, 256'd0);
        chk("hold_idle", {255'd0, busy}, 256'd0);

        // Reset two rounds into an operation
        @(negedge clk);
        start = 1'b1; mode = 1'b0; key = 64'd15; data_in = 256'd20;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {255'd0, busy}, 256'd0);
        chk("abort_done", {255'd0, done}, 256'd0);
        chk("abort_data_out", data_out, 256'd0);
        chk("abort_check_ok", {255'd0, check_ok}, 256'd0);
        doneSeen = '0;
        for (int e = 0; e < 4; e++) begin
            @(posedge clk); #1;
            doneSeen[e] = done;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 4; e < 8; e++) begin
            @(posedge clk); #1;
            doneSeen[e] = done;
        end
        chk("abort_no_done", {245'd0, doneSeen}, 256'd0);
        runOp(1'b0, 64'd0, 256'd20, res, ok, lat);
        chk("post_reset_latency", 256'(lat), 256'd4);
        chk("post_reset_data", res, CT_K0);

        // Random round trips
        for (int it = 0; it < 1000; it++) begin
            for (int w = 0; w < 8; w++) p[w*32 +: 31] = 31'($urandom);
            for (int w = 0; w < 8; w++) p[w*32+31 +: 1] = 1'($urandom);
            k = {$urandom, $urandom};
            runOp(1'b0, k, {8'($urandom_range(0, 255)), p}, ct, ok, lat);
            chk("rand_enc_check_ok", {255'd0, ok}, 256'd1);
            runOp(1'b1, k, ct, res, ok, lat);
            chk("rand_roundtrip", res, {refChk(p), p});
            chk("rand_dec_check_ok", {255'd0, ok}, 256'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
